// File: rtl/cdb_pkg.sv
// Shared constants for the Common Data Bus: sizes, requester indices and the
// reserved "no producer" label value.
package cdb_pkg;

    localparam int CDB_DW     = 32;
    localparam int CDB_LW     = 4;
    localparam int CDB_NREQ   = 4;

    localparam int REQ_ALU    = 0;
    localparam int REQ_MUL    = 1;
    localparam int REQ_DIV    = 2;
    localparam int REQ_MEM    = 3;

    localparam int LABEL_NONE = 0;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Requester and broadcast signals of the CDB arbiter; master is the arbiter,
// slave is the environment (functional units and CDB consumers).
interface cdb_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int LW   = 4
);
    logic                       flush;
    logic [NREQ-1:0]            req;
    logic [NREQ*DW-1:0]         data_in;
    logic [NREQ*LW-1:0]         label_in;
    logic [NREQ-1:0]            ack;
    logic                       BCEN;
    logic [LW-1:0]              BClabel;
    logic [DW-1:0]              BCdata;
    logic                       bad_label;
    logic [$clog2(NREQ)-1:0]    ptr_out;

    modport master (
        input  flush, req, data_in, label_in,
        output ack, BCEN, BClabel, BCdata, bad_label, ptr_out
    );

    modport slave (
        output flush, req, data_in, label_in,
        input  ack, BCEN, BClabel, BCdata, bad_label, ptr_out
    );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping.
// Purely combinational; NREQ must be a power of two so ptr+k wraps for free.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + PW'(k);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB arbiter: same-cycle one-hot ack, registered broadcast of the
// winner's label/data one cycle later, and a pulse when a label-0 result is consumed.
module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int NREQ = CDB_NREQ,
    parameter int DW   = CDB_DW,
    parameter int LW   = CDB_LW
) (
    input logic              clk,
    input logic              RST,
    cdb_rr_arbiter_if.master bus
);

    localparam int PW = $clog2(NREQ);

    generate
        if (!is_pow2(NREQ)) begin : g_bad_nreq
            $error("cdb_rr_arbiter: NREQ must be a power of two >= 2");
        end
    endgenerate

    logic [NREQ-1:0] grant_p0;
    logic [PW-1:0]   idx_p0;
    logic            vld_p0;
    logic            take_p0;
    logic [LW-1:0]   label_p0;
    logic [DW-1:0]   data_p0;

    logic [PW-1:0]   ptr_p1;
    logic            bcen_p1;
    logic [LW-1:0]   bclabel_p1;
    logic [DW-1:0]   bcdata_p1;
    logic            bad_p1;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_p1),
        .grant (grant_p0),
        .idx   (idx_p0),
        .valid (vld_p0)
    );

    // Stage 0: combinational pick and same-cycle acknowledge
    assign take_p0  = vld_p0 && !bus.flush && !RST;
    assign bus.ack  = take_p0 ? grant_p0 : '0;
    assign label_p0 = bus.label_in[idx_p0*LW +: LW];
    assign data_p0  = bus.data_in[idx_p0*DW +: DW];

    // Stage 1: broadcast register; a label-0 winner is consumed but not broadcast
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ptr_p1     <= '0;
            bcen_p1    <= 1'b0;
            bclabel_p1 <= '0;
            bcdata_p1  <= '0;
            bad_p1     <= 1'b0;
        end else if (take_p0) begin
            ptr_p1 <= idx_p0 + PW'(1);
            if (label_p0 != LW'(LABEL_NONE)) begin
                bcen_p1    <= 1'b1;
                bclabel_p1 <= label_p0;
                bcdata_p1  <= data_p0;
                bad_p1     <= 1'b0;
            end else begin
                bcen_p1 <= 1'b0;
                bad_p1  <= 1'b1;
            end
        end else begin
            bcen_p1 <= 1'b0;
            bad_p1  <= 1'b0;
        end
    end

    assign bus.BCEN      = bcen_p1;
    assign bus.BClabel   = bclabel_p1;
    assign bus.BCdata    = bcdata_p1;
    assign bus.bad_label = bad_p1;
    assign bus.ptr_out   = ptr_p1;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter: reset, rotation, wrap/skip, label-0,
// flush collision and asynchronous reset during a broadcast.
module tb_cdb_rr_arbiter;
    import cdb_pkg::*;

    localparam int NREQ = CDB_NREQ;
    localparam int DW   = CDB_DW;
    localparam int LW   = CDB_LW;

    logic clk;
    logic RST;
    int   n_checks;
    int   n_errors;

    logic [NREQ-1:0]    held_q;
    logic [NREQ*DW-1:0] data_q;
    logic [NREQ*LW-1:0] label_q;

    cdb_rr_arbiter_if #(.NREQ(NREQ), .DW(DW), .LW(LW)) bus ();

    cdb_rr_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
        bus.label_in[i*LW +: LW] = l;
        bus.data_in[i*DW +: DW]  = d;
    endtask

    task automatic check_bc(input string tag, input logic en, input logic [LW-1:0] l,
                            input logic [DW-1:0] d, input logic bad, input logic [1:0] p);
        check({tag, ".BCEN"}, 64'(bus.BCEN), 64'(en));
        if (en) begin
            check({tag, ".BClabel"}, 64'(bus.BClabel), 64'(l));
            check({tag, ".BCdata"}, 64'(bus.BCdata), 64'(d));
        end
        check({tag, ".bad_label"}, 64'(bus.bad_label), 64'(bad));
        check({tag, ".ptr"}, 64'(bus.ptr_out), 64'(p));
    endtask

    // A requester held without ack must keep its label/data stable
    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (held_q[i] && bus.req[i] && !RST)
                check("hold_stable",
                      64'({bus.data_in[i*DW +: DW], bus.label_in[i*LW +: LW]}),
                      64'({data_q[i*DW +: DW], label_q[i*LW +: LW]}));
        end
        held_q  = RST ? '0 : (bus.req & ~bus.ack);
        data_q  = bus.data_in;
        label_q = bus.label_in;
    end

    initial begin
        logic [LW-1:0] lbl [NREQ];
        n_checks     = 0;
        n_errors     = 0;
        held_q       = '0;
        data_q       = '0;
        label_q      = '0;
        RST          = 1'b1;
        bus.flush    = 1'b0;
        bus.req      = '0;
        bus.data_in  = '0;
        bus.label_in = '0;
        lbl[0] = 4'd1; lbl[1] = 4'd5; lbl[2] = 4'd9; lbl[3] = 4'd13;

        // Test 1: reset state, then single request
        #2;
        set_src(REQ_ALU, 4'h3, 32'h0000_00AA);
        bus.req = 4'b0001;
        #10;
        check("rst.ack", 64'(bus.ack), 64'(0));
        check_bc("rst", 1'b0, '0, '0, 1'b0, 2'd0);
        check("rst.BClabel", 64'(bus.BClabel), 64'(0));
        check("rst.BCdata", 64'(bus.BCdata), 64'(0));
        RST = 1'b0;
        #1;
        check("t1.ack", 64'(bus.ack), 64'(4'b0001));
        tick();
        check_bc("t1", 1'b1, 4'h3, 32'h0000_00AA, 1'b0, 2'd1);
        bus.req = '0;
        #1;
        check("t1.idle_ack", 64'(bus.ack), 64'(0));
        tick();
        check_bc("t1.idle", 1'b0, '0, '0, 1'b0, 2'd1);
        check("t1.hold_label", 64'(bus.BClabel), 64'(4'h3));

        // Test 2: all four continuously from ptr 0
        RST = 1'b1;
        #2;
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) set_src(i, lbl[i], 32'h100 + 32'(i));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t2.ack%0d", k), 64'(bus.ack), 64'(4'b0001 << (k % 4)));
            tick();
            check_bc($sformatf("t2.bc%0d", k), 1'b1, lbl[k % 4], 32'h100 + 32'(k % 4),
                     1'b0, 2'((k + 1) % 4));
        end

        // Test 3: advance to ptr 3, then req=0101 wraps past index 3 to 0
        for (int k = 1; k < 3; k++) begin
            #1;
            check($sformatf("t3.pre_ack%0d", k), 64'(bus.ack), 64'(4'b0001 << k));
            tick();
        end
        check("t3.ptr3", 64'(bus.ptr_out), 64'(3));
        bus.req = 4'b0101;
        #1;
        check("t3.ack_wrap", 64'(bus.ack), 64'(4'b0001));
        tick();
        check_bc("t3.bc0", 1'b1, lbl[0], 32'h100, 1'b0, 2'd1);
        bus.req = 4'b0100;
        #1;
        check("t3.ack_next", 64'(bus.ack), 64'(4'b0100));
        tick();
        check_bc("t3.bc2", 1'b1, lbl[2], 32'h102, 1'b0, 2'd3);
        bus.req = '0;

        // Test 4: label-zero request is consumed with a bad_label pulse
        set_src(REQ_MUL, 4'h0, 32'h0000_0BAD);
        bus.req = 4'b0010;
        #1;
        check("t4.ack", 64'(bus.ack), 64'(4'b0010));
        tick();
        check_bc("t4.bad", 1'b0, '0, '0, 1'b1, 2'd2);
        bus.req = '0;
        tick();
        check_bc("t4.after", 1'b0, '0, '0, 1'b0, 2'd2);

        // Test 5: flush for two cycles blocks a pending MEM request
        bus.req   = 4'b1000;
        bus.flush = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("t5.flush_ack%0d", k), 64'(bus.ack), 64'(0));
            tick();
            check_bc($sformatf("t5.flush%0d", k), 1'b0, '0, '0, 1'b0, 2'd2);
        end
        bus.flush = 1'b0;
        #1;
        check("t5.ack", 64'(bus.ack), 64'(4'b1000));
        tick();
        check_bc("t5.bc", 1'b1, lbl[3], 32'h103, 1'b0, 2'd0);

        // Test 6: asynchronous reset between edges while BCEN=1
        #2;
        RST = 1'b1;
        #1;
        check("t6.BCEN", 64'(bus.BCEN), 64'(0));
        check("t6.BClabel", 64'(bus.BClabel), 64'(0));
        check("t6.BCdata", 64'(bus.BCdata), 64'(0));
        check("t6.ptr", 64'(bus.ptr_out), 64'(0));
        check("t6.ack", 64'(bus.ack), 64'(0));
        bus.req = '0;
        #1;
        RST = 1'b0;
        bus.req = 4'b1000;
        #1;
        check("t6.ack_after", 64'(bus.ack), 64'(4'b1000));
        tick();
        check_bc("t6.bc_after", 1'b1, lbl[3], 32'h103, 1'b0, 2'd0);
        bus.req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Registered round-robin arbiter and driver for the Common Data Bus (CDB) in the Tomasulo core.
- Replaces fixed-priority selection between the functional-unit result sources: ALU, MUL, DIV and load/store memory.
- Each cycle it grants at most one requester, acknowledges it in the same cycle, and drives BCEN/BClabel/BCdata from a register one cycle later. These outputs feed the reservation stations, queues and register file.
- Round-robin guarantees every requester a grant within NREQ cycles.

Parameters:
NREQ, 4, number of CDB requesters (index 0 ALU, 1 MUL, 2 DIV, 3 MEM)
DW, 32, broadcast data width
LW, 4, reservation-station label width; label 0 means "no producer"

Ports:
clk  in  1  rising-edge clock
RST  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash: no grant this cycle, broadcast register cleared
req  in  NREQ  per-source request; held high until acked
data_in  in  NREQ*DW  result data, slice i belongs to source i
label_in  in  NREQ*LW  result label, slice i belongs to source i
ack  out  NREQ  one-hot grant, combinational, same cycle as the winning req
BCEN  out  1  broadcast valid (registered)
BClabel  out  LW  broadcast label (registered)
BCdata  out  DW  broadcast data (registered)
bad_label  out  1  registered one-cycle pulse: the granted request carried label 0
ptr_out  out  log2(NREQ)  current round-robin pointer, for debug and verification

Behaviour:
- Reset (RST=1, asynchronous):
  - BCEN=0, BClabel=0, BCdata=0, bad_label=0, ptr=0.
  - ack forced to 0 while RST is high.
- Requester handshake:
  - A source raises req[i] with stable data_in/label_in slices.
  - It holds them until the rising edge at which ack[i]=1, then may drop req or present a new result in the next cycle.
  - Data changing while req is high and ack is low is a protocol violation; the bench asserts on it.
- Arbitration, combinational each cycle:
  - Search order is ptr, ptr+1, ... wrapping modulo NREQ. The first i with req[i]=1 wins.
  - ack = onehot(winner). ack = 0 when no req is high, or when flush=1, or when RST=1.
- Registered update at the edge, when a grant g exists:
  - If label slice g != 0: BCEN<=1, BClabel<=label_in[g], BCdata<=data_in[g], bad_label<=0.
  - If label slice g == 0: BCEN<=0, bad_label<=1. The request is still acked (consumed) to avoid deadlock.
  - ptr<=(g+1) mod NREQ.
- Registered update at the edge, when there is no grant:
  - BCEN<=0, bad_label<=0.
  - BClabel and BCdata hold their previous values; consumers must ignore them while BCEN=0.
  - ptr unchanged.
- Flush: BCEN<=0, bad_label<=0, ptr unchanged, no ack. A requester pending at that time keeps req high and is arbitrated after flush drops.
- Latency: ack in cycle N, broadcast visible in cycle N+1 for exactly one cycle. Throughput is one broadcast per cycle.
- Fairness: with all NREQ requesting continuously, grants rotate strictly 0,1,2,3,0,... starting from ptr. Maximum wait is NREQ-1 cycles after req rises.
- Reset mid-operation: any in-flight broadcast is lost (BCEN drops asynchronously). Requesters must be reset by the same RST.
- The pointer wraps from NREQ-1 to 0. NREQ must be a power of two ≥2; the implementation includes an elaboration-time check for this.

Decomposition:
- Shared package cdb_pkg holds:
  - constants CDB_DW=32, CDB_LW=4, CDB_NREQ=4;
  - requester indices REQ_ALU=0, REQ_MUL=1, REQ_DIV=2, REQ_MEM=3;
  - LABEL_NONE=0.
- One natural sub-module, rr_pick: purely combinational rotate-priority encoder. Inputs are req and ptr; outputs are onehot grant, grant index and a valid flag.
- The broadcast register, pointer register and bad_label logic stay in cdb_rr_arbiter.

Test Plan:
1. Reset, then single request: RST pulse, then req=0001, label0=4'h3, data0=32'h0000_00AA. Expect ack=0001 in the same cycle; next cycle BCEN=1, BClabel=3, BCdata=AA, ptr_out=1.
2. All four requesting continuously from ptr=0, labels 1,5,9,13. Expect ack sequence 0001,0010,0100,1000,0001. Expect BClabel sequence 1,5,9,13,1, each one cycle after its ack.
3. Wrap and skip: ptr=3, req=0101. Expect ack=0001 (index 3 skipped, wraps to 0). Next grant ack=0100; ptr_out then 3.
4. Label-zero request: req=0010 with label1=0. Expect ack=0010; next cycle BCEN=0, bad_label=1 for one cycle; ptr_out=2.
5. Flush collision: req=1000 with flush=1 for 2 cycles. Expect ack=0, BCEN=0 and ptr unchanged throughout. When flush drops, ack=1000 that cycle and the broadcast follows one cycle later.
6. Asynchronous reset mid-broadcast: assert RST between clock edges while BCEN=1. BCEN, BClabel, BCdata and ptr_out must go to 0 immediately, without waiting for a clock edge.
